sipo_rx: RTL and testbench

- Serial-in/parallel-out receiver. It is the receiving end of the team's 4-bit PISO shift-register link, which sends MSB first on a single serial line.
- Collects WIDTH serial bits per frame, qualified by a start strobe and a per-bit enable.
- Presents each completed word on a held valid/ready output register.
- Flags an overrun when the consumer has not taken the previous word.

---
 rtl/sipo_rx_if.sv | 27 ++
 rtl/sipo_rx.sv | 138 +++++++++++++
 tb/tb_sipo_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// sipo_rx_if - serial receive link plus parallel output handshake.
//   master : serial sender / word consumer side (drives si, si_en, start, po_ready)
//   slave  : sipo_rx side (drives po, po_valid, busy, overrun[, par_err])
// Macro SIPO_RX_PARITY_EN adds par_err.
interface sipo_rx_if #(parameter int WIDTH = 4);
  logic             si;
  logic             si_en;
  logic             start;
  logic             po_ready;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             busy;
  logic             overrun;
`ifdef SIPO_RX_PARITY_EN
  logic             par_err;

  modport master (output si, si_en, start, po_ready,
                  input  po, po_valid, busy, overrun, par_err);
  modport slave  (input  si, si_en, start, po_ready,
                  output po, po_valid, busy, overrun, par_err);
`else
  modport master (output si, si_en, start, po_ready,
                  input  po, po_valid, busy, overrun);
  modport slave  (input  si, si_en, start, po_ready,
                  output po, po_valid, busy, overrun);
`endif
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx - serial-in/parallel-out receiver for the 4-bit PISO link.
// Collects WIDTH bits per frame (start marks bit 0, si_en qualifies each bit)
// and offers the word to a held valid/ready output register. A word that
// completes while the previous one is still unconsumed is dropped and the
// sticky overrun flag is set.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low
//   bus  : sipo_rx_if.slave (si, si_en, start, po_ready in;
//          po, po_valid, busy, overrun[, par_err] out)
// Option macro SIPO_RX_PARITY_EN: one even-parity bit follows the data bits,
// a PARITY state samples it, and par_err is loaded together with po.
//
// state  | meaning
// IDLE   | waiting for si_en=1 with start=1
// SHIFT  | collecting data bits 1..WIDTH-1
// PARITY | waiting for the parity bit (SIPO_RX_PARITY_EN only)
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic     clk,
  input logic     rst,
  sipo_rx_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_base, sr_shift, word, po_r;
  logic [CW-1:0]    cnt;
  logic             pv_r, ovr_r;
  logic             take_first, take_data, last_data, complete, busy;
`ifdef SIPO_RX_PARITY_EN
  logic             perr_r, perr_word;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic; start=1 with si_en=1 restarts from any state
  always_comb begin
    state_nxt = state;
    if (take_first) begin
      state_nxt = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (last_data) begin
`ifdef SIPO_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = IDLE;
`endif
          end
        end
`ifdef SIPO_RX_PARITY_EN
        PARITY: if (complete) state_nxt = IDLE;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // output / control decode
  always_comb begin
    take_first = bus.si_en & bus.start;
    take_data  = (state == SHIFT) & bus.si_en & ~bus.start;
    last_data  = take_data & (cnt == CW'(WIDTH - 1));
    busy       = (state != IDLE);
    // a new frame shifts into an all-zero register so bit 0 lands cleanly
    sr_base    = take_first ? '0 : sr;
    if (MSB_FIRST) sr_shift = {sr_base[WIDTH-2:0], bus.si};
    else           sr_shift = {bus.si, sr_base[WIDTH-1:1]};
`ifdef SIPO_RX_PARITY_EN
    complete  = (state == PARITY) & bus.si_en & ~bus.start;
    word      = sr;
    perr_word = (^sr) ^ bus.si;
`else
    complete  = last_data;
    word      = sr_shift;
`endif
  end

  // shift register, bit counter and output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr     <= '0;
      cnt    <= '0;
      po_r   <= '0;
      pv_r   <= 1'b0;
      ovr_r  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      perr_r <= 1'b0;
`endif
    end else begin
      if (take_first) begin
        sr  <= sr_shift;
        cnt <= CW'(1);
      end else if (take_data) begin
        sr  <= sr_shift;
        cnt <= last_data ? '0 : cnt + 1'b1;
      end

      if (complete) begin
        if (!pv_r || bus.po_ready) begin
          po_r   <= word;
          pv_r   <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
          perr_r <= perr_word;
`endif
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (pv_r && bus.po_ready) begin
        pv_r <= 1'b0;
      end
    end
  end

  assign bus.po       = po_r;
  assign bus.po_valid = pv_r;
  assign bus.busy     = busy;
  assign bus.overrun  = ovr_r;
`ifdef SIPO_RX_PARITY_EN
  assign bus.par_err  = perr_r;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sipo_rx_if #(.WIDTH(4)) bus ();
  sipo_rx_if #(.WIDTH(4)) bus_l ();

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus));
  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  typedef struct {
    logic       rst, si, en, st, rdy;
    logic [3:0] po;
    logic       pv, busy, ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic e, input logic t,
                     input logic y, input logic [3:0] p, input logic v,
                     input logic b, input logic o);
    vec_t x;
    x.rst = r; x.si = s; x.en = e; x.st = t; x.rdy = y;
    x.po = p; x.pv = v; x.busy = b; x.ovr = o;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic e, input logic t, input logic y);
    bus.si = s; bus.si_en = e; bus.start = t; bus.po_ready = y;
  endtask

  task automatic drive_l(input logic s, input logic e, input logic t, input logic y);
    bus_l.si = s; bus_l.si_en = e; bus_l.start = t; bus_l.po_ready = y;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    drive_l(0, 0, 0, 0);

`ifndef SIPO_RX_PARITY_EN
    //   rst si en st rdy  po      pv busy ovr
    add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);  // 0 reset
    add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 0, 1, 0);  // 2 basic 1011
    add(1, 0, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b1011, 1, 0, 0);
    add(1, 0, 0, 0, 1, 4'b1011, 0, 0, 0);  // 6 consume
    add(1, 0, 1, 1, 0, 4'b1011, 0, 1, 0);  // 7 stall 0110
    add(1, 1, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b1011, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b1011, 0, 1, 0);  // start without si_en ignored
    add(1, 1, 1, 0, 0, 4'b1011, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1011, 0, 1, 0);
    add(1, 0, 1, 0, 0, 4'b0110, 1, 0, 0);  // 13
    add(1, 0, 0, 0, 1, 4'b0110, 0, 0, 0);
    add(1, 1, 1, 1, 1, 4'b0110, 0, 1, 0);  // 15 back-to-back, ready held
    add(1, 0, 1, 0, 1, 4'b0110, 0, 1, 0);
    add(1, 1, 1, 0, 1, 4'b0110, 0, 1, 0);
    add(1, 1, 1, 0, 1, 4'b1011, 1, 0, 0);
    add(1, 0, 1, 1, 1, 4'b1011, 0, 1, 0);  // no gap; consumed here
    add(1, 1, 1, 0, 1, 4'b1011, 0, 1, 0);
    add(1, 0, 1, 0, 1, 4'b1011, 0, 1, 0);
    add(1, 1, 1, 0, 1, 4'b0101, 1, 0, 0);  // 22
    add(1, 0, 0, 0, 1, 4'b0101, 0, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0101, 0, 1, 0);  // 24 overrun
    add(1, 0, 1, 0, 0, 4'b0101, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0101, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b1011, 1, 0, 0);
    add(1, 0, 1, 1, 0, 4'b1011, 1, 1, 0);
    add(1, 1, 1, 0, 0, 4'b1011, 1, 1, 0);
    add(1, 0, 1, 0, 0, 4'b1011, 1, 1, 0);
    add(1, 1, 1, 0, 0, 4'b1011, 1, 0, 1);  // 31 dropped
    add(1, 0, 0, 0, 1, 4'b1011, 0, 0, 1);
    add(1, 0, 0, 0, 0, 4'b1011, 0, 0, 1);  // sticky
    add(1, 1, 1, 1, 0, 4'b1011, 0, 1, 1);  // 34 restart
    add(1, 1, 1, 0, 0, 4'b1011, 0, 1, 1);
    add(1, 1, 1, 1, 0, 4'b1011, 0, 1, 1);
    add(1, 1, 1, 0, 0, 4'b1011, 0, 1, 1);
    add(1, 0, 1, 0, 0, 4'b1011, 0, 1, 1);
    add(1, 0, 1, 0, 0, 4'b1100, 1, 0, 1);  // 39
    add(1, 1, 1, 1, 1, 4'b1100, 0, 1, 1);  // 40 consume + new frame
    add(1, 0, 1, 0, 0, 4'b1100, 0, 1, 1);
    add(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0);  // 42 mid-frame reset
    add(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 0, 1, 0);  // 44 1011 after reset
    add(1, 0, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b1011, 1, 0, 0);
    add(1, 0, 1, 1, 0, 4'b1011, 1, 1, 0);  // 48 complete with ready=1
    add(1, 1, 1, 0, 0, 4'b1011, 1, 1, 0);
    add(1, 0, 1, 0, 0, 4'b1011, 1, 1, 0);
    add(1, 1, 1, 0, 1, 4'b0101, 1, 0, 0);
    add(1, 0, 0, 0, 0, 4'b0101, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].si, vecs[i].en, vecs[i].st, vecs[i].rdy);
      tick();
      chk($sformatf("row%0d po", i),       32'(bus.po),       32'(vecs[i].po));
      chk($sformatf("row%0d po_valid", i), 32'(bus.po_valid), 32'(vecs[i].pv));
      chk($sformatf("row%0d busy", i),     32'(bus.busy),     32'(vecs[i].busy));
      chk($sformatf("row%0d overrun", i),  32'(bus.overrun),  32'(vecs[i].ovr));
    end
`else
    rst = 1'b0;
    tick();
    tick();
    chk("par reset po_valid", 32'(bus.po_valid), 32'd0);
    chk("par reset par_err",  32'(bus.par_err),  32'd0);
    chk("par reset busy",     32'(bus.busy),     32'd0);
    rst = 1'b1;
    drive(1, 1, 1, 0); tick();
    drive(0, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    chk("par wait busy",     32'(bus.busy),     32'd1);
    chk("par wait po_valid", 32'(bus.po_valid), 32'd0);
    drive(1, 1, 0, 0); tick();
    chk("par good po",       32'(bus.po),       32'hb);
    chk("par good po_valid", 32'(bus.po_valid), 32'd1);
    chk("par good par_err",  32'(bus.par_err),  32'd0);
    chk("par good busy",     32'(bus.busy),     32'd0);
    drive(0, 0, 0, 1); tick();
    chk("par consume", 32'(bus.po_valid), 32'd0);
    drive(1, 1, 1, 0); tick();
    drive(0, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(0, 1, 0, 0); tick();
    chk("par bad po",       32'(bus.po),       32'hb);
    chk("par bad par_err",  32'(bus.par_err),  32'd1);
    chk("par bad po_valid", 32'(bus.po_valid), 32'd1);
    drive(0, 0, 0, 0);
`endif

    // LSB-first: bits 1,0,0,0 -> 4'b0001
    drive_l(1, 1, 1, 0); tick();
    chk("lsb busy", 32'(bus_l.busy), 32'd1);
    drive_l(0, 1, 0, 0); tick();
    drive_l(0, 1, 0, 0); tick();
    drive_l(0, 1, 0, 0); tick();
`ifdef SIPO_RX_PARITY_EN
    drive_l(1, 1, 0, 0); tick();
    chk("lsb par_err", 32'(bus_l.par_err), 32'd0);
`endif
    chk("lsb po",       32'(bus_l.po),       32'h1);
    chk("lsb po_valid", 32'(bus_l.po_valid), 32'd1);
    chk("lsb busy end", 32'(bus_l.busy),     32'd0);
    drive_l(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
